// File: rtl/rider_qual_n.sv
`default_nettype none
// ============================================================================
// Module   : rider_qual_n
// Purpose  : Rider qualification from a bank of load cells. Sums the left and
//            right halves of the cell bank, registers the total and the signed
//            left-right difference, and runs a small state machine that
//            decides when steering may be enabled. The machine waits for the
//            rider to mount and settle, debounces step-off, and latches a
//            fault when any cell reads full scale.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            single clock
//   rst          in   1            synchronous active-high reset
//   ld_vld       in   1            new sample present on ld_cells
//   ld_cells     in   N*LD_W       packed samples, cell i at [i*LD_W +: LD_W]
//   ld_sum       out  SW+1         registered left+right sum
//   ld_cell_diff out  SW+1         registered signed left-right difference
//   en_steer     out  1            steering enable (registered)
//   rider_off    out  1            no rider qualified (IDLE or FAULT)
//   step_off     out  1            one-cycle pulse on step-off
//   fault        out  1            cell saturation fault
//   state        out  2            0=IDLE 1=WAIT 2=STEER_EN 3=FAULT
// ============================================================================
module rider_qual_n #(
  parameter int          NUM_CELLS    = 4,
  parameter int          LD_W         = 12,
  parameter int          FAST_SIM     = 0,
  parameter logic [25:0] SETTLE_CNT   = 26'h3DFD240,
  parameter int          MIN_WEIGHT   = 'h200,
  parameter int          HYST         = 'h020,
  parameter int          STEPOFF_HOLD = 3,
  // Width of one half-bank sum; the total and the difference need one more bit.
  localparam int         SW           = LD_W + $clog2(NUM_CELLS / 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_vld,
  input  logic [NUM_CELLS*LD_W-1:0] ld_cells,
  output logic [SW:0]               ld_sum,
  output logic signed [SW:0]        ld_cell_diff,
  output logic                      en_steer,
  output logic                      rider_off,
  output logic                      step_off,
  output logic                      fault,
  output logic [1:0]                state
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_half      = NUM_CELLS / 2;
  localparam logic [31:0] c_min_wt    = 32'(MIN_WEIGHT);
  localparam logic [31:0] c_mount_thr = 32'(MIN_WEIGHT + HYST);
  localparam logic [25:0] c_settle    = (FAST_SIM != 0) ? 26'h0007FFF : SETTLE_CNT;
  localparam logic [3:0]  c_hold      = 4'(STEPOFF_HOLD);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_STEER_EN = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SW-1:0]               w_left;
  logic [SW-1:0]               w_right;
  logic [SW:0]                 w_sum;
  logic signed [SW:0]          w_diff;

  logic [NUM_CELLS*LD_W-1:0]   r_cells;
  logic [SW:0]                 r_ld_sum;
  logic signed [SW:0]          r_ld_diff;
  logic                        r_samp_new;

  logic [NUM_CELLS-1:0]        w_cell_sat;
  logic                        w_sat;
  logic [SW:0]                 w_abs;
  logic [31:0]                 w_sum32;
  logic                        w_mount;
  logic                        w_low;
  logic                        w_unbal;
  logic                        w_stepoff_diff;

  state_t                      r_state;
  state_t                      w_next;
  logic                        w_tmr_clr;
  logic [25:0]                 r_timer;
  logic [3:0]                  r_low_cnt;
  logic                        r_en_steer;
  logic                        r_step_off;

  // --------------------------------------------------------------------------
  // Half-bank sums. Each half has at most NUM_CELLS/2 cells of LD_W bits, so
  // SW bits hold it exactly; one extra bit holds the total and the signed
  // difference without loss.
  // --------------------------------------------------------------------------
  always_comb begin
    w_left  = '0;
    w_right = '0;
    for (int i = 0; i < c_half; i++) begin
      w_left  = w_left  + SW'(ld_cells[i*LD_W +: LD_W]);
      w_right = w_right + SW'(ld_cells[(i+c_half)*LD_W +: LD_W]);
    end
  end

  assign w_sum  = {1'b0, w_left} + {1'b0, w_right};
  assign w_diff = $signed({1'b0, w_left}) - $signed({1'b0, w_right});

  // --------------------------------------------------------------------------
  // Sample registers: update only when a sample is presented. r_samp_new
  // marks the first cycle the freshly registered values are visible.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cells    <= '0;
      r_ld_sum   <= '0;
      r_ld_diff  <= '0;
      r_samp_new <= 1'b0;
    end else begin
      r_samp_new <= ld_vld;
      if (ld_vld) begin
        r_cells   <= ld_cells;
        r_ld_sum  <= w_sum;
        r_ld_diff <= w_diff;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Qualification flags, all derived from the registered sample.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell_sat
    assign w_cell_sat[g] = &r_cells[g*LD_W +: LD_W];
  end

  assign w_sat = |w_cell_sat;

  // Magnitude of the difference; the most negative value cannot occur since
  // each half is strictly below 2**SW, so negation never overflows.
  always_comb begin
    w_abs = r_ld_diff[SW] ? $unsigned(-r_ld_diff) : $unsigned(r_ld_diff);
  end

  assign w_sum32        = 32'(r_ld_sum);
  assign w_mount        = (w_sum32 > c_mount_thr);
  assign w_low          = (w_sum32 < c_min_wt);
  assign w_unbal        = (w_abs > (r_ld_sum >> 2));
  assign w_stepoff_diff = (w_abs > (r_ld_sum - (r_ld_sum >> 4)));

  // --------------------------------------------------------------------------
  // State machine: next-state and timer-clear decisions.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_tmr_clr = 1'b0;
    if (w_sat) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mount) begin
            w_next    = S_WAIT;
            w_tmr_clr = 1'b1;
          end
        end
        S_WAIT: begin
          if (r_low_cnt == c_hold) begin
            w_next = S_IDLE;
          end else if (w_unbal) begin
            // Rider is shifting weight: restart the settle interval.
            w_tmr_clr = 1'b1;
          end else if (r_timer >= c_settle) begin
            w_next = S_STEER_EN;
          end
        end
        S_STEER_EN: begin
          if (r_low_cnt == c_hold) begin
            w_next = S_IDLE;
          end else if (w_stepoff_diff) begin
            // Almost all weight on one side: drop back and re-settle.
            w_next    = S_WAIT;
            w_tmr_clr = 1'b1;
          end
        end
        S_FAULT: begin
          // Saturation is already known clear here; wait for a fresh sample
          // so recovery is based on real data, not the stale faulting one.
          if (r_samp_new) begin
            w_next = S_IDLE;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_en_steer <= 1'b0;
      r_step_off <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_en_steer <= (w_next == S_STEER_EN);
      r_step_off <= (w_next == S_IDLE) &&
                    ((r_state == S_WAIT) || (r_state == S_STEER_EN));
    end
  end

  // --------------------------------------------------------------------------
  // Settle timer: counts only in WAIT and sticks at all-ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_tmr_clr) begin
      r_timer <= '0;
    end else if ((r_state == S_WAIT) && (r_timer != '1)) begin
      r_timer <= r_timer + 26'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Step-off debounce: counts consecutive low samples, saturating at the
  // hold count so the exit condition stays asserted until acted upon.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_low_cnt <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_FAULT)) begin
      r_low_cnt <= '0;
    end else if (r_samp_new) begin
      if (!w_low) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt < c_hold) begin
        r_low_cnt <= r_low_cnt + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ld_sum       = r_ld_sum;
  assign ld_cell_diff = r_ld_diff;
  assign en_steer     = r_en_steer;
  assign step_off     = r_step_off;
  assign rider_off    = (r_state == S_IDLE) || (r_state == S_FAULT);
  assign fault        = (r_state == S_FAULT);
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rider_qual_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rider_qual_n
// Purpose  : Self-checking bench for rider_qual_n. Two instances share the
//            sample inputs: one with the fast-sim settle count, one with a
//            short settle count for scenarios that need repeated entry into
//            STEER_EN. A behavioural model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rider_qual_n;

  localparam int NC   = 4;
  localparam int LW   = 12;
  localparam int SWB  = 13;
  localparam int MINW = 'h200;
  localparam int HYS  = 'h20;
  localparam int HOLD = 3;
  localparam int TMAX = 67108863;

  logic             clk = 1'b0;
  logic             rst_a;
  logic             rst_b;
  logic             ld_vld;
  logic [NC*LW-1:0] ld_cells;
  logic             sel;

  logic [SWB:0]        a_sum, b_sum, sum_m;
  logic signed [SWB:0] a_diff, b_diff, diff_m;
  logic                a_en, b_en, en_m;
  logic                a_ro, b_ro, ro_m;
  logic                a_so, b_so, so_m;
  logic                a_flt, b_flt, flt_m;
  logic [1:0]          a_st, b_st, st_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model state
  int m_cell [NC];
  int m_sum, m_diff, m_state, m_timer, m_low, m_vld_d, m_en, m_step, m_settle;

  always #5 clk = ~clk;

  rider_qual_n #(
    .NUM_CELLS(NC), .LD_W(LW), .FAST_SIM(1), .SETTLE_CNT(26'h3DFD240),
    .MIN_WEIGHT(MINW), .HYST(HYS), .STEPOFF_HOLD(HOLD)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .ld_vld(ld_vld), .ld_cells(ld_cells),
    .ld_sum(a_sum), .ld_cell_diff(a_diff), .en_steer(a_en), .rider_off(a_ro),
    .step_off(a_so), .fault(a_flt), .state(a_st)
  );

  rider_qual_n #(
    .NUM_CELLS(NC), .LD_W(LW), .FAST_SIM(0), .SETTLE_CNT(26'd40),
    .MIN_WEIGHT(MINW), .HYST(HYS), .STEPOFF_HOLD(HOLD)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .ld_vld(ld_vld), .ld_cells(ld_cells),
    .ld_sum(b_sum), .ld_cell_diff(b_diff), .en_steer(b_en), .rider_off(b_ro),
    .step_off(b_so), .fault(b_flt), .state(b_st)
  );

  assign sum_m  = sel ? b_sum  : a_sum;
  assign diff_m = sel ? b_diff : a_diff;
  assign en_m   = sel ? b_en   : a_en;
  assign ro_m   = sel ? b_ro   : a_ro;
  assign so_m   = sel ? b_so   : a_so;
  assign flt_m  = sel ? b_flt  : a_flt;
  assign st_m   = sel ? b_st   : a_st;

  function automatic logic [NC*LW-1:0] pk(input logic [11:0] c0, input logic [11:0] c1,
                                          input logic [11:0] c2, input logic [11:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Reference model: advances one clock from the inputs presented to it.
  task automatic model_step(input logic r, input logic v, input logic [NC*LW-1:0] c);
    int  ns, abs_d, lsum, rsum;
    bit  tclr, sat, mount, low, unbal, sod, samp;
    if (r) begin
      m_state = 0; m_sum = 0; m_diff = 0; m_timer = 0; m_low = 0;
      m_en = 0; m_step = 0; m_vld_d = 0;
      for (int i = 0; i < NC; i++) m_cell[i] = 0;
    end else begin
      abs_d = (m_diff < 0) ? -m_diff : m_diff;
      mount = (m_sum > MINW + HYS);
      low   = (m_sum < MINW);
      unbal = (abs_d > m_sum / 4);
      sod   = (abs_d > m_sum - m_sum / 16);
      sat   = 0;
      for (int i = 0; i < NC; i++) if (m_cell[i] == 4095) sat = 1;
      samp  = (m_vld_d != 0);
      ns    = m_state;
      tclr  = 0;
      if (sat) ns = 3;
      else if (m_state == 0) begin
        if (mount) begin ns = 1; tclr = 1; end
      end else if (m_state == 1) begin
        if (m_low == HOLD) ns = 0;
        else if (unbal) tclr = 1;
        else if (m_timer >= m_settle) ns = 2;
      end else if (m_state == 2) begin
        if (m_low == HOLD) ns = 0;
        else if (sod) begin ns = 1; tclr = 1; end
      end else begin
        if (samp) ns = 0;
      end
      if (tclr) m_timer = 0;
      else if (m_state == 1 && m_timer < TMAX) m_timer = m_timer + 1;
      if (m_state == 0 || m_state == 3) m_low = 0;
      else if (samp) m_low = low ? ((m_low < HOLD) ? m_low + 1 : m_low) : 0;
      m_en   = (ns == 2) ? 1 : 0;
      m_step = (ns == 0 && (m_state == 1 || m_state == 2)) ? 1 : 0;
      if (v) begin
        lsum = 0; rsum = 0;
        for (int i = 0; i < NC; i++) begin
          m_cell[i] = int'(c[i*LW +: LW]);
          if (i < NC / 2) lsum += m_cell[i]; else rsum += m_cell[i];
        end
        m_sum  = lsum + rsum;
        m_diff = lsum - rsum;
      end
      m_vld_d = v ? 1 : 0;
      m_state = ns;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sum"},   32'(sum_m),       32'(m_sum));
    check({tag, ".diff"},  32'(int'(diff_m)), 32'(m_diff));
    check({tag, ".en"},    32'(en_m),        32'(m_en));
    check({tag, ".roff"},  32'(ro_m),        (m_state == 0 || m_state == 3) ? 32'd1 : 32'd0);
    check({tag, ".stoff"}, 32'(so_m),        32'(m_step));
    check({tag, ".fault"}, 32'(flt_m),       (m_state == 3) ? 32'd1 : 32'd0);
    check({tag, ".state"}, 32'(st_m),        32'(m_state));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after edge.
  task automatic cyc(input logic r, input logic v, input logic [NC*LW-1:0] c,
                     input bit chk, input string tag);
    if (sel) begin rst_b = r; rst_a = 1'b1; end
    else     begin rst_a = r; rst_b = 1'b1; end
    ld_vld   = v;
    ld_cells = c;
    model_step(r, v, c);
    @(posedge clk);
    #1;
    if (chk) check_all(tag);
  endtask

  initial begin
    logic [NC*LW-1:0] p100, p40, pun, psat, c;
    int rb;
    p100 = pk(12'h100, 12'h100, 12'h100, 12'h100);
    p40  = pk(12'h040, 12'h040, 12'h040, 12'h040);
    pun  = pk(12'h180, 12'h180, 12'h080, 12'h080);
    psat = pk(12'h100, 12'h100, 12'hFFF, 12'h100);
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1; ld_vld = 1'b0; ld_cells = '0;
    m_settle = 'h7FFF;

    // ---------------- instance A: fast-sim settle ----------------
    cyc(1, 0, '0, 1, "reset");
    cyc(1, 0, '0, 1, "reset");
    check("rst_state", 32'(st_m), 32'd0);
    check("rst_roff",  32'(ro_m), 32'd1);

    // mount
    cyc(0, 1, p100, 1, "mount");
    check("mount_sum",  32'(sum_m), 32'h400);
    check("mount_diff", 32'(int'(diff_m)), 32'd0);
    cyc(0, 1, p100, 1, "mount");
    check("mount_wait", 32'(st_m), 32'd1);
    for (int i = 0; i < 'h7FFF; i++) cyc(0, 1, p100, (i % 2048 == 0) || (i > 'h7FF0), "settle");
    check("settle_pre_en", 32'(en_m), 32'd0);
    cyc(0, 1, p100, 1, "settle");
    check("settle_en",    32'(en_m), 32'd1);
    check("settle_steer", 32'(st_m), 32'd2);

    // step-off debounce: two lows then a high keeps steering
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, p40, 1, "deb");
      cyc(0, 0, p40, 1, "deb");
      cyc(0, 0, p40, 1, "deb");
    end
    cyc(0, 1, p100, 1, "deb");
    for (int k = 0; k < 3; k++) cyc(0, 0, p100, 1, "deb");
    check("deb_hold_state", 32'(st_m), 32'd2);
    // three lows in a row step off
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, p40, 1, "stoff");
      cyc(0, 0, p40, 1, "stoff");
      cyc(0, 0, p40, 1, "stoff");
    end
    check("so_state", 32'(st_m), 32'd0);
    check("so_pulse", 32'(so_m), 32'd1);
    check("so_roff",  32'(ro_m), 32'd1);
    cyc(0, 0, p40, 1, "stoff");
    check("so_pulse_end", 32'(so_m), 32'd0);

    // unbalanced: mounts but never settles
    for (int i = 0; i < 300; i++) cyc(0, 1, pun, 1, "unbal");
    check("unbal_diff",  32'(int'(diff_m)), 32'h200);
    check("unbal_state", 32'(st_m), 32'd1);
    check("unbal_en",    32'(en_m), 32'd0);

    // ---------------- instance B: short settle ----------------
    sel = 1'b1;
    m_settle = 40;
    cyc(1, 0, '0, 1, "resetb");
    cyc(1, 0, '0, 1, "resetb");
    for (int i = 0; i < 60; i++) cyc(0, 1, p100, 1, "mountb");
    check("b_steer", 32'(st_m), 32'd2);

    // saturation
    cyc(0, 1, psat, 1, "sat");
    cyc(0, 0, psat, 1, "sat");
    check("sat_state", 32'(st_m),  32'd3);
    check("sat_en",    32'(en_m),  32'd0);
    check("sat_fault", 32'(flt_m), 32'd1);
    cyc(0, 0, psat, 1, "sat");
    cyc(0, 1, p100, 1, "sat_rec");
    cyc(0, 0, p100, 1, "sat_rec");
    check("sat_rec_state", 32'(st_m), 32'd0);
    check("sat_rec_stoff", 32'(so_m), 32'd0);

    // reset while steering
    for (int i = 0; i < 60; i++) cyc(0, 1, p100, 1, "mountb2");
    check("b_steer2", 32'(st_m), 32'd2);
    cyc(1, 1, p100, 1, "midrst");
    check("midrst_state", 32'(st_m), 32'd0);
    check("midrst_en",    32'(en_m), 32'd0);
    check("midrst_stoff", 32'(so_m), 32'd0);
    check("midrst_sum",   32'(sum_m), 32'd0);

    // randomized traffic around the thresholds
    rb = 'h100;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) rb = $urandom_range(0, 'h1C0);
      for (int j = 0; j < NC; j++) c[j*LW +: LW] = 12'(rb + $urandom_range(0, 'h3F));
      if ($urandom_range(0, 7) == 0)  c[11:0] = 12'($urandom_range(0, 'hFFE));
      if ($urandom_range(0, 63) == 0) c[$urandom_range(0, NC-1)*LW +: LW] = 12'hFFF;
      cyc(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), c, 1, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
